// File: rtl/c_result_sink.sv
`timescale 1ns/1ps
// c_result_sink
//   Consumer of the compute_wrapper C stream. Captures each beat into a local
//   result buffer, checks that tlast lands exactly on beat cfg_beats, raises
//   sticky done / one-cycle done_pulse / maskable irq, and exposes the buffer
//   through a registered read port.
// Ports
//   clk, rst                  single clock, synchronous active-high reset
//   s_axis_c_*                AXI-Stream C input (tdata/tvalid/tready/tlast)
//   cfg_beats, arm            job length, sampled on the 1-cycle arm pulse
//   clear_done, irq_en        SW status clear, interrupt enable
//   rd_addr, rd_data          buffer readback, 1-cycle latency
//   beat_count, busy, done, done_pulse, err_*, irq   job status
module c_result_sink #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_axis_c_tdata,
  input  logic              s_axis_c_tvalid,
  output logic              s_axis_c_tready,
  input  logic              s_axis_c_tlast,
  input  logic [15:0]       cfg_beats,
  input  logic              arm,
  input  logic              clear_done,
  input  logic              irq_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [AW:0]       beat_count,
  output logic              busy,
  output logic              done,
  output logic              done_pulse,
  output logic              err_early_last,
  output logic              err_no_last,
  output logic              err_cfg,
  output logic              irq
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       exp_beats;
  logic [AW:0]       beat_next;
  logic              cfg_ok;
  logic              beat_hs;
  logic              hit_exp;

  always_comb begin
    cfg_ok    = (cfg_beats != '0) && ({1'b0, cfg_beats} <= DEPTH_L);
    beat_hs   = s_axis_c_tvalid && s_axis_c_tready;
    beat_next = beat_count + (AW+1)'(1);
    hit_exp   = (beat_next == exp_beats);
  end

  assign irq = done & irq_en;

  // tready and busy are registered copies of (state == CAPTURE) so they
  // change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      s_axis_c_tready <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      done_pulse      <= 1'b0;
      err_early_last  <= 1'b0;
      err_no_last     <= 1'b0;
      err_cfg         <= 1'b0;
      beat_count      <= '0;
      exp_beats       <= '0;
    end else begin
      done_pulse <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          // arm takes priority over clear_done; an illegal arm leaves the state alone
          if (arm) begin
            if (cfg_ok) begin
              state           <= CAPTURE;
              s_axis_c_tready <= 1'b1;
              busy            <= 1'b1;
              done            <= 1'b0;
              exp_beats       <= cfg_beats[AW:0];
              beat_count      <= '0;
              err_early_last  <= 1'b0;
              err_no_last     <= 1'b0;
              err_cfg         <= 1'b0;
            end else begin
              err_cfg <= 1'b1;
            end
          end else if (clear_done) begin
            state          <= IDLE;
            done           <= 1'b0;
            err_early_last <= 1'b0;
            err_no_last    <= 1'b0;
            err_cfg        <= 1'b0;
          end
        end
        CAPTURE: begin
          if (beat_hs) begin
            beat_count <= beat_next;
            if (hit_exp || s_axis_c_tlast) begin
              state           <= DONE;
              s_axis_c_tready <= 1'b0;
              busy            <= 1'b0;
              done            <= 1'b1;
              done_pulse      <= 1'b1;
              if (!hit_exp)
                err_early_last <= 1'b1;
              else if (!s_axis_c_tlast)
                err_no_last <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && beat_hs)
      mem[beat_count[AW-1:0]] <= s_axis_c_tdata;
  end

  // Non-blocking read of mem gives old data on a same-address write.
  always_ff @(posedge clk) begin
    if (rst)
      rd_data <= '0;
    else
      rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_c_result_sink.sv
`timescale 1ns/1ps
module tb_c_result_sink;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int AW     = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] s_axis_c_tdata = '0;
  logic              s_axis_c_tvalid = 1'b0;
  logic              s_axis_c_tready;
  logic              s_axis_c_tlast = 1'b0;
  logic [15:0]       cfg_beats = '0;
  logic              arm = 1'b0;
  logic              clear_done = 1'b0;
  logic              irq_en = 1'b0;
  logic [AW-1:0]     rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic [AW:0]       beat_count;
  logic              busy, done, done_pulse;
  logic              err_early_last, err_no_last, err_cfg, irq;

  always #5 clk = ~clk;

  c_result_sink #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis_c_tdata (s_axis_c_tdata),
    .s_axis_c_tvalid(s_axis_c_tvalid),
    .s_axis_c_tready(s_axis_c_tready),
    .s_axis_c_tlast (s_axis_c_tlast),
    .cfg_beats      (cfg_beats),
    .arm            (arm),
    .clear_done     (clear_done),
    .irq_en         (irq_en),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .beat_count     (beat_count),
    .busy           (busy),
    .done           (done),
    .done_pulse     (done_pulse),
    .err_early_last (err_early_last),
    .err_no_last    (err_no_last),
    .err_cfg        (err_cfg),
    .irq            (irq)
  );

  typedef struct {
    int acc;
    bit early;
    bit nolast;
  } job_t;

  int          nvec = 0;
  int          nfail = 0;
  int          pulse_cnt = 0;
  job_t        job_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] beat_data [DEPTH+1];
  logic [31:0] mem_m [DEPTH];
  logic        rd_en = 1'b0;
  logic        rd_en_s;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: pops expected read data and expected job results when the DUT presents them.
  initial begin
    job_t j;
    forever begin
      @(posedge clk);
      rd_en_s = rd_en;
      #1;
      if (rd_en_s) begin
        if (rd_q.size() == 0) begin
          nvec++; nfail++;
          $display("FAIL rd_unexpected: got 0x%0h, expected no read", rd_data);
        end else begin
          chk("rd_data", rd_data, rd_q.pop_front());
        end
      end
      if (done_pulse === 1'b1) begin
        pulse_cnt++;
        if (job_q.size() == 0) begin
          nvec++; nfail++;
          $display("FAIL done_pulse_unexpected: got pulse, expected none");
        end else begin
          j = job_q.pop_front();
          chk("job_beat_count", beat_count, j.acc);
          chk("job_err_early_last", err_early_last, j.early);
          chk("job_err_no_last", err_no_last, j.nolast);
          chk("job_err_cfg", err_cfg, 0);
          chk("job_done", done, 1);
          chk("job_busy", busy, 0);
          chk("job_tready", s_axis_c_tready, 0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic do_arm(input int cfg, input bit clr);
    @(negedge clk);
    arm = 1'b1; cfg_beats = 16'(cfg); clear_done = clr;
    @(negedge clk);
    arm = 1'b0; clear_done = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_done = 1'b1;
    @(negedge clk);
    clear_done = 1'b0;
    chk("clear_done", done, 0);
    chk("clear_irq", irq, 0);
    chk("clear_errs", {err_early_last, err_no_last, err_cfg}, 0);
  endtask

  // Offers beats from beat_data; a beat counts when tready is seen with tvalid up.
  task automatic send(input int n_offer, input int last_at, input int gap,
                      input int max_cyc, output int acc);
    acc = 0;
    for (int c = 0; c < max_cyc && acc < n_offer; c++) begin
      @(negedge clk);
      if (gap > 0 && $urandom_range(99) < gap) begin
        s_axis_c_tvalid = 1'b0; s_axis_c_tlast = 1'b0;
      end else begin
        s_axis_c_tvalid = 1'b1;
        s_axis_c_tdata  = beat_data[acc];
        s_axis_c_tlast  = (acc + 1 == last_at);
        if (s_axis_c_tready) acc++;
      end
    end
    @(negedge clk);
    s_axis_c_tvalid = 1'b0; s_axis_c_tlast = 1'b0;
  endtask

  task automatic readback(input int n);
    for (int a = 0; a < n; a++) begin
      @(negedge clk);
      rd_addr = AW'(a); rd_en = 1'b1;
      rd_q.push_back(mem_m[a]);
    end
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  // last_at = 0 means no tlast within the job.
  task automatic run_job(input int e, input int last_at, input int gap,
                         input bit clr_with_arm, input bit keep_data);
    job_t j;
    int   acc, offer, p0;
    if (!keep_data)
      for (int i = 0; i <= e; i++) beat_data[i] = $urandom;
    if (last_at >= 1 && last_at <= e) begin
      j.acc = last_at; j.early = (last_at < e); j.nolast = 1'b0; offer = last_at;
    end else begin
      j.acc = e; j.early = 1'b0; j.nolast = 1'b1; offer = e + 1;
    end
    for (int i = 0; i < j.acc; i++) mem_m[i] = beat_data[i];
    p0 = pulse_cnt;
    job_q.push_back(j);
    do_arm(e, clr_with_arm);
    chk("arm_busy", busy, 1);
    chk("arm_done", done, 0);
    chk("arm_tready", s_axis_c_tready, 1);
    chk("arm_beat_count", beat_count, 0);
    send(offer, last_at, gap, 8 * e + 40, acc);
    chk("accepted_beats", acc, j.acc);
    for (int k = 0; k < 40 && done !== 1'b1; k++) @(negedge clk);
    chk("done_set", done, 1);
    repeat (2) @(negedge clk);
    chk("pulse_count", pulse_cnt - p0, 1);
    chk("done_sticky", done, 1);
    chk("tready_low_in_done", s_axis_c_tready, 0);
    chk("beat_count_hold", beat_count, j.acc);
    chk("irq_level", irq, irq_en);
    readback(j.acc);
  endtask

  initial begin
    int acc;
    repeat (3) @(negedge clk);
    chk("rst_outputs",
        {s_axis_c_tready, busy, done, done_pulse, err_early_last, err_no_last, err_cfg, irq}, 0);
    chk("rst_beat_count", beat_count, 0);
    chk("rst_rd_data", rd_data, 0);
    rst = 1'b0;

    // T1 / T2: fixed data, then same data with 50% valid gaps
    for (int i = 0; i < 4; i++) beat_data[i] = 32'hC0 + 32'(i);
    run_job(4, 4, 0, 1'b0, 1'b1);
    do_clear();
    run_job(4, 4, 50, 1'b0, 1'b1);
    do_clear();

    // T3 early tlast, T4 missing tlast (beat 5 held off)
    run_job(4, 2, 0, 1'b0, 1'b0);
    do_clear();
    run_job(4, 0, 0, 1'b0, 1'b0);
    do_clear();

    // T5 illegal lengths and irq
    do_arm(0, 1'b0);
    chk("cfg0_err", err_cfg, 1);
    chk("cfg0_busy", busy, 0);
    do_clear();
    do_arm(65, 1'b0);
    chk("cfg65_err", err_cfg, 1);
    chk("cfg65_busy", busy, 0);
    do_clear();
    irq_en = 1'b1;
    run_job(3, 3, 0, 1'b0, 1'b0);
    chk("irq_on_done", irq, 1);
    do_clear();

    // full-depth job
    run_job(DEPTH, DEPTH, 20, 1'b0, 1'b0);
    do_clear();

    // T6 reset mid-capture, then clean job, then arm+clear_done in DONE
    for (int i = 0; i < 4; i++) beat_data[i] = $urandom;
    do_arm(4, 1'b0);
    send(2, 0, 0, 20, acc);
    chk("pre_rst_accepted", acc, 2);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("midrst_outputs",
        {s_axis_c_tready, busy, done, done_pulse, err_early_last, err_no_last, err_cfg}, 0);
    chk("midrst_beat_count", beat_count, 0);
    chk("midrst_rd_data", rd_data, 0);
    run_job(4, 4, 0, 1'b0, 1'b0);
    run_job(3, 3, 0, 1'b1, 1'b0);

    // random jobs
    for (int n = 0; n < 12; n++) begin
      int e, l;
      e = $urandom_range(10, 1);
      l = $urandom_range(e + 1, 0);
      irq_en = 1'($urandom_range(1, 0));
      if ($urandom_range(1, 0) == 1) do_clear();
      run_job(e, l, 30, 1'($urandom_range(1, 0)), 1'b0);
    end

    repeat (4) @(negedge clk);
    if (job_q.size() != 0 || rd_q.size() != 0) begin
      nvec++; nfail++;
      $display("FAIL leftover_expectations: got %0d jobs %0d reads pending, expected 0",
               job_q.size(), rd_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
